// File: rtl/rv32_pipe_ctrl.sv
// rv32_pipe_ctrl: load-use scoreboard, redirect flush, halt-drain FSM and stall counter for the 5-stage RV32 core
module rv32_pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_rf_ctrl,
  input  logic [4:0]       id_pc_ctrl,
  input  logic             ex_redirect,
  output logic             if_stall,
  output logic             id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
  state_e            state_q, state_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [2:0]        v_q, v_d, ld_q, ld_d;
  logic [2:0][4:0]   rd_q, rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              redirect, hazard, unused;
  assign unused = ^{id_pc_ctrl[3:0], v_q[2], ld_q[2], rd_q[2]};
  assign stall_cnt = stall_cnt_q;
  // Entry 0 is EX, 1 is MEM, 2 is WB; only the EX entry can cause a load-use stall.
  always_comb begin
    redirect     = ex_redirect & (state_q != HALTED);
    hazard       = id_valid & v_q[0] & ld_q[0] & (|rd_q[0]) &
                   ((rd_q[0] == id_rs1) | (rd_q[0] == id_rs2));
    if_stall     = ~redirect & ((state_q != RUN) | hazard);
    id_stall     = if_stall;
    id_ex_bubble = if_stall | redirect;
    if_id_flush  = redirect;
    halted       = state_q == HALTED;
    v_d          = {v_q[1:0], id_valid & id_rf_ctrl[0] & (|id_rd) & ~id_ex_bubble};
    ld_d         = {ld_q[1:0], &id_rf_ctrl[2:1]};
    rd_d         = {rd_q[1:0], id_rd};
    stall_cnt_d  = stall_cnt_q + CNT_W'(if_stall & ~&stall_cnt_q);
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    if (state_q == RUN && id_valid && !id_pc_ctrl[4] && !ex_redirect) begin
      state_d = DRAIN;
      dcnt_d  = DW'(DRAIN_CYCLES - 1);
    end else if (state_q == DRAIN) begin
      state_d = redirect ? RUN : (dcnt_q == '0) ? HALTED : DRAIN;
      dcnt_d  = (redirect || dcnt_q == '0) ? dcnt_q : dcnt_q - DW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      dcnt_q      <= '0;
      v_q         <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      v_q         <= v_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_rv32_pipe_ctrl.sv
// tb_rv32_pipe_ctrl: directed vector table, hand sequences and randomized model check of rv32_pipe_ctrl
module tb_rv32_pipe_ctrl;
  logic clk = 0;
  logic rst, id_valid, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd, id_pc_ctrl;
  logic [2:0] id_rf_ctrl;
  logic if_stall, id_stall, id_ex_bubble, if_id_flush, halted;
  logic [31:0] stall_cnt;
  logic if_stall4, id_stall4, id_ex_bubble4, if_id_flush4, halted4;
  logic [3:0] stall_cnt4;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  rv32_pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rf_ctrl(id_rf_ctrl), .id_pc_ctrl(id_pc_ctrl), .ex_redirect(ex_redirect),
    .if_stall(if_stall), .id_stall(id_stall), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .halted(halted), .stall_cnt(stall_cnt));

  rv32_pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rf_ctrl(id_rf_ctrl), .id_pc_ctrl(id_pc_ctrl), .ex_redirect(ex_redirect),
    .if_stall(if_stall4), .id_stall(id_stall4), .id_ex_bubble(id_ex_bubble4),
    .if_id_flush(if_id_flush4), .halted(halted4), .stall_cnt(stall_cnt4));

  typedef struct {
    logic rst, vld;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] rf;
    logic pce, redir;
    logic [4:0] exp;
  } vec_t;

  // Reference model: last three instructions issued into EX plus halt progress.
  bit pv[3], pld[3];
  int prd[3];
  int drain_left, sc;
  bit mhalt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic vl, input int s1, input int s2,
                              input int d, input int rf, input logic pce, input logic rd_ir,
                              input logic [4:0] exp);
    vec_t v;
    v.rst = r; v.vld = vl; v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.rd = 5'(d);
    v.rf = 3'(rf); v.pce = pce; v.redir = rd_ir; v.exp = exp;
    return v;
  endfunction

  // mode 0: no check, 1: table expectation, 2: model expectation
  task automatic cycle(input vec_t v, input int mode);
    bit redir, hz, stl, bub;
    logic [4:0] mexp;
    @(negedge clk);
    rst = v.rst; id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_rf_ctrl = v.rf; id_pc_ctrl = {v.pce, 4'b0001}; ex_redirect = v.redir;
    #1;
    redir = v.redir && !mhalt;
    hz = v.vld && pv[0] && pld[0] && prd[0] != 0 && (prd[0] == int'(v.rs1) || prd[0] == int'(v.rs2));
    stl = !redir && (mhalt || drain_left > 0 || hz);
    bub = stl || redir;
    mexp = {stl, stl, bub, redir, mhalt};
    if (mode == 1) check("strobes_tbl", {if_stall, id_stall, id_ex_bubble, if_id_flush, halted}, v.exp);
    if (mode == 2) check("strobes_rand", {if_stall, id_stall, id_ex_bubble, if_id_flush, halted}, mexp);
    if (mode != 0) begin
      check("stall_cnt", stall_cnt, sc);
      check("stall_cnt4", stall_cnt4, (sc > 15) ? 15 : sc);
    end
    if (v.rst) begin
      pv = '{0, 0, 0}; pld = '{0, 0, 0}; prd = '{0, 0, 0};
      drain_left = 0; mhalt = 0; sc = 0;
    end else begin
      pv[2] = pv[1]; pld[2] = pld[1]; prd[2] = prd[1];
      pv[1] = pv[0]; pld[1] = pld[0]; prd[1] = prd[0];
      pv[0] = v.vld && v.rf[0] && v.rd != 0 && !bub;
      pld[0] = v.rf[2:1] == 2'b11;
      prd[0] = int'(v.rd);
      if (stl) sc++;
      if (!mhalt) begin
        if (drain_left > 0) begin
          if (redir) drain_left = 0;
          else if (drain_left == 1) begin drain_left = 0; mhalt = 1; end
          else drain_left--;
        end else if (v.vld && !v.pce && !v.redir) drain_left = 3;
      end
    end
  endtask

  vec_t tbl[$];
  vec_t idle, rstv, haltw, rv;

  initial begin
    rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rf_ctrl = 0; id_pc_ctrl = 5'b10001; ex_redirect = 0;
    pv = '{0, 0, 0}; pld = '{0, 0, 0}; prd = '{0, 0, 0};
    drain_left = 0; mhalt = 0; sc = 0;
    idle  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000);
    rstv  = mk(1, 0, 0, 0, 0, 0, 1, 0, 5'b00000);
    haltw = mk(0, 1, 31, 31, 31, 0, 0, 0, 5'b00000);
    // lw = rf 3'b111, alu write = rf 3'b001; exp = {if_stall,id_stall,bubble,flush,halted}
    tbl.push_back(mk(0, 1, 1, 0, 5, 7, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 5, 2, 6, 1, 1, 0, 5'b11100));
    tbl.push_back(mk(0, 1, 5, 2, 6, 1, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 1, 0, 5, 7, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 5, 2, 6, 1, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 1, 0, 0, 7, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 0, 2, 6, 1, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 1, 0, 5, 1, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 5, 5, 6, 1, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 1, 0, 5, 7, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 5, 2, 6, 1, 1, 1, 5'b00110));
    tbl.push_back(mk(0, 1, 5, 2, 6, 1, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 1, 0, 7, 7, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 1, 7, 8, 1, 1, 0, 5'b11100));
    tbl.push_back(mk(0, 1, 1, 7, 8, 1, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 31, 31, 31, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11101));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b11101));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 5'b11101));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 31, 31, 31, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b00110));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
    tbl.push_back(mk(0, 1, 31, 31, 31, 0, 0, 1, 5'b00110));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000));

    cycle(rstv, 0);
    cycle(rstv, 0);
    cycle(idle, 1);
    foreach (tbl[i]) cycle(tbl[i], 1);

    // Long halt: counters saturate only in the narrow instance.
    cycle(rstv, 0);
    cycle(haltw, 1);
    repeat (25) cycle(idle, 0);
    @(negedge clk); #1;
    check("halted_sticky", halted, 1);
    check("stall_cnt_25", stall_cnt, 25);
    check("stall_cnt4_sat", stall_cnt4, 15);
    cycle(rstv, 0);
    @(negedge clk); #1;
    check("rst_halted", halted, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_if_stall", if_stall, 0);

    for (int i = 0; i < 1500; i++) begin
      rv.rst = $urandom_range(0, 99) == 0;
      rv.vld = $urandom_range(0, 3) != 0;
      rv.rs1 = 5'($urandom_range(0, 7));
      rv.rs2 = 5'($urandom_range(0, 7));
      rv.rd = 5'($urandom_range(0, 7));
      rv.rf = 3'($urandom_range(0, 7));
      rv.pce = $urandom_range(0, 40) != 0;
      rv.redir = $urandom_range(0, 7) == 0;
      rv.exp = 0;
      cycle(rv, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
